// File: rtl/gs_signal_bank.sv
// Double-buffered raw-signal bank: captures ADC sweeps into a shadow page per slot and
// serves registered 16-bit reads to the Gs command FSM from the committed page.
module gs_signal_bank #(
    parameter int DEPTH       = 67,
    parameter int NUM_SIGNALS = 4,
    parameter int DATA_W      = 16
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iTrigger,
    input  logic [7:0]        i8ChanSel,
    input  logic              iSampleValid,
    input  logic [DATA_W-1:0] i16Sample,
    input  logic [7:0]        i8Addr,
    input  logic [7:0]        i8SignSelec,
    output logic [DATA_W-1:0] o16Reg,
    output logic              oBusy,
    output logic              oSweepDone,
    output logic [7:0]        o8DropCnt
);

    localparam int CNT_W  = $clog2(DEPTH);
    localparam int SLOT_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
    localparam int WORDS  = 2 * NUM_SIGNALS * DEPTH;
    localparam int IDX_W  = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SWAP    = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [CNT_W-1:0]       count;
    logic [SLOT_W-1:0]      slot;
    logic [NUM_SIGNALS-1:0] pageBit;
    logic [NUM_SIGNALS-1:0] validBit;
    logic [DATA_W-1:0]      mem [WORDS];

    logic              trigOk;
    logic              writeEn;
    logic              lastWrite;
    logic              dropEv;
    logic              wrPage;
    logic [IDX_W-1:0]  wrIdx;
    logic [SLOT_W-1:0] rdSel;
    logic              rdOk;
    logic [IDX_W-1:0]  rdIdx;

    // Flattened {page, slot, sample} word index into the single storage array.
    function automatic logic [IDX_W-1:0] memIdx(input logic page, input logic [SLOT_W-1:0] s,
                                                input logic [7:0] a);
        return IDX_W'((int'(page) * NUM_SIGNALS + int'(s)) * DEPTH + int'(a));
    endfunction

    assign trigOk    = iTrigger && (i8ChanSel < 8'(NUM_SIGNALS));
    assign writeEn   = (state == CAPTURE) && iSampleValid;
    assign lastWrite = writeEn && (count == CNT_W'(DEPTH - 1));
    // Any trigger that does not start a sweep is a drop, including one landing on SWAP.
    assign dropEv    = iTrigger && !((state == IDLE) && trigOk);
    assign wrPage    = ~pageBit[slot];
    assign wrIdx     = memIdx(wrPage, slot, 8'(count));

    assign rdSel = i8SignSelec[SLOT_W-1:0];
    assign rdOk  = (i8SignSelec < 8'(NUM_SIGNALS)) && (i8Addr < 8'(DEPTH)) && validBit[rdSel];
    assign rdIdx = rdOk ? memIdx(pageBit[rdSel], rdSel, i8Addr) : '0;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        stateNext  = state;
        oBusy      = 1'b0;
        oSweepDone = 1'b0;
        case (state)
            IDLE: begin
                if (trigOk) stateNext = CAPTURE;
            end
            CAPTURE: begin
                oBusy = 1'b1;
                if (lastWrite) stateNext = SWAP;
            end
            SWAP: begin
                oBusy      = 1'b1;
                oSweepDone = 1'b1;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state     <= IDLE;
            count     <= '0;
            slot      <= '0;
            pageBit   <= '0;
            validBit  <= '0;
            o8DropCnt <= '0;
        end else begin
            state <= stateNext;
            if ((state == IDLE) && trigOk) begin
                slot  <= i8ChanSel[SLOT_W-1:0];
                count <= '0;
            end else if (writeEn) begin
                count <= count + CNT_W'(1);
            end
            // Commit flips only this slot's page, so other slots keep their sweeps untouched.
            if (state == SWAP) begin
                pageBit[slot]  <= ~pageBit[slot];
                validBit[slot] <= 1'b1;
            end
            if (dropEv && (o8DropCnt != 8'hFF)) o8DropCnt <= o8DropCnt + 8'd1;
        end
    end

    // NOTE: the sample storage is deliberately left out of reset; validBit gates stale contents.
    always_ff @(posedge iClk) begin
        if (writeEn) mem[wrIdx] <= i16Sample;
    end

    // Reads always address the committed page, so a same-cycle shadow write is never visible.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) o16Reg <= '0;
        else         o16Reg <= rdOk ? mem[rdIdx] : '0;
    end

endmodule
